sar_ctrl: RTL and testbench

//  Successive-approximation controller for the differential SAR-ADC model.
//  - Sequences one conversion: drives the sample/hold track clock, then runs NBIT comparator bit-trials.
//  - Drives the trial code to the capacitive DAC.
//  - Latches the result and flags it with a 1-cycle valid pulse.
//  - Sits between the top-level conversion request and the sample_hold, DAC and comparator models.

---
 rtl/sar_if.sv | 25 ++
 rtl/sar_ctrl.sv | 108 ++++++++++
 tb/tb_sar_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_if.sv
// Handshake and data bundle between the SAR controller and the converter front end.
interface sar_if #(
  parameter int NBIT = 8
);
  logic            start;
  logic            comp;
  logic            sh_track;
  logic            comp_en;
  logic [NBIT-1:0] dac_code;
  logic [NBIT-1:0] dout;
  logic            valid;
  logic            busy;

  modport master (
    input  start, comp,
    output sh_track, comp_en, dac_code,
    output dout, valid, busy
  );

  modport slave (
    output start, comp,
    input  sh_track, comp_en, dac_code,
    input  dout, valid, busy
  );
endinterface

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: S/H tracking, then NBIT
// MSB-first comparator trials. Produces a 1-cycle valid pulse with each result.
module sar_ctrl #(
  parameter int NBIT       = 8,
  parameter int SAMPLE_CYC = 2
) (
  input  logic   clk,
  input  logic   rst,
  sar_if.master  bus
);
  localparam int CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int IW = $clog2(NBIT);

  // one-hot so every output decode is a single flop bit
  localparam int S_IDLE   = 0;
  localparam int S_SAMPLE = 1;
  localparam int S_CONV   = 2;
  localparam int S_DONE   = 3;

  logic [3:0]      state;
  logic [3:0]      nxt;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_m1;
  logic [NBIT-1:0] sar;
  logic [NBIT-1:0] trial;
  logic [NBIT-1:0] res;
  logic            keep;

  assign keep   = (bus.comp === 1'b1);
  assign idx_m1 = idx - IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= 4'b0001;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[S_IDLE]:
        if (bus.start) nxt = 4'b0010;
      state[S_SAMPLE]:
        if (cnt == '0) nxt = 4'b0100;
      state[S_CONV]:
        if (idx == '0) nxt = 4'b1000;
      state[S_DONE]:
        nxt = bus.start ? 4'b0010 : 4'b0001;
      default:
        nxt = 4'b0001;
    endcase
  end

  always_comb begin
    trial      = sar;
    trial[idx] = keep;
    if (idx != '0) trial[idx_m1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
      sar <= '0;
      res <= '0;
    end else begin
      unique case (1'b1)
        state[S_IDLE]: begin
          sar <= '0;
          if (bus.start) cnt <= CW'(SAMPLE_CYC - 1);
        end
        state[S_SAMPLE]: begin
          if (cnt == '0) begin
            sar <= {1'b1, {(NBIT-1){1'b0}}};
            idx <= IW'(NBIT - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        state[S_CONV]: begin
          sar <= trial;
          if (idx != '0) idx <= idx_m1;
          else           res <= trial;
        end
        state[S_DONE]: begin
          sar <= '0;
          if (bus.start) cnt <= CW'(SAMPLE_CYC - 1);
        end
        default: sar <= '0;
      endcase
    end
  end

  always_comb begin
    bus.sh_track = state[S_SAMPLE];
    bus.comp_en  = state[S_CONV];
    bus.valid    = state[S_DONE];
    bus.busy     = ~state[S_IDLE];
    bus.dac_code = sar;
    bus.dout     = res;
  end

  always @(posedge clk) begin
    if (rst && state[S_CONV])
      assert (!$isunknown(bus.comp))
      else $warning("sar_ctrl: comp unknown, bit cleared");
  end
endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator model
// and a valid-driven scoreboard.
module tb_sar_ctrl;
  logic clk;
  logic rst;
  logic [7:0] vin;
  int mode;
  int checks;
  int errors;
  int vcnt;
  int cyc;
  logic prev_v;
  logic [7:0] exp_q[$];

  sar_if #(.NBIT(8)) bus ();

  sar_ctrl #(.NBIT(8), .SAMPLE_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always_comb begin
    case (mode)
      0:       bus.comp = (vin >= bus.dac_code);
      1:       bus.comp = 1'b1;
      2:       bus.comp = 1'b0;
      default: bus.comp = 1'bx;
    endcase
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid) begin
      vcnt++;
      if (exp_q.size() == 0)
        check("unexpected_valid", 32'(bus.dout), 32'hFFFF_FFFF);
      else
        check("sb_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      check("valid_1cyc", 32'(prev_v), 32'd0);
    end
    if (bus.sh_track | bus.comp_en | bus.valid)
      check("busy_active", 32'(bus.busy), 32'd1);
    prev_v = bus.valid;
  end

  task automatic pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tab [8];
    logic [7:0] v3 [3];
    logic [7:0] e6;
    int v0, n, last;
    tab = '{8'h80, 8'hC0, 8'hA0, 8'hB0,
            8'hA8, 8'hA4, 8'hA6, 8'hA5};
    v3 = '{8'h00, 8'hFF, 8'h5A};
    checks = 0; errors = 0; vcnt = 0; cyc = 0;
    prev_v = 1'b0; mode = 0; vin = '0;
    bus.start = 1'b0;
    rst = 1'b0;
    #12;
    check("rst_sh", 32'(bus.sh_track), 0);
    check("rst_cen", 32'(bus.comp_en), 0);
    check("rst_dac", 32'(bus.dac_code), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0xA5, cycle-by-cycle sequence
    vin = 8'hA5;
    exp_q.push_back(8'hA5);
    pulse();
    for (int k = 0; k < 12; k++) begin
      logic [7:0] ed;
      ed = 8'h00;
      if (k >= 2 && k <= 9) ed = tab[k-2];
      if (k == 10) ed = 8'hA5;
      check("t1_sh", 32'(bus.sh_track), 32'(k < 2));
      check("t1_dac", 32'(bus.dac_code), 32'(ed));
      check("t1_cen", 32'(bus.comp_en), 32'(k >= 2 && k <= 9));
      check("t1_valid", 32'(bus.valid), 32'(k == 10));
      check("t1_busy", 32'(bus.busy), 32'(k <= 10));
      if (k < 11) @(negedge clk);
    end

    // 2: forced comparator
    v0 = vcnt;
    mode = 1;
    exp_q.push_back(8'hFF);
    pulse();
    repeat (12) @(negedge clk);
    #1 check("t2_one_valid_a", 32'(vcnt - v0), 1);
    check("t2_dout_ff", 32'(bus.dout), 32'hFF);
    v0 = vcnt;
    mode = 2;
    exp_q.push_back(8'h00);
    pulse();
    repeat (12) @(negedge clk);
    #1 check("t2_one_valid_b", 32'(vcnt - v0), 1);
    check("t2_dout_00", 32'(bus.dout), 0);
    mode = 0;

    // 3: back-to-back with start held
    @(negedge clk);
    vin = v3[0];
    foreach (v3[i]) exp_q.push_back(v3[i]);
    bus.start = 1'b1;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.valid && n < 40);
      check("t3_valid_seen", 32'(bus.valid), 1);
      if (i > 0) check("t3_period", 32'(cyc - last), 11);
      last = cyc;
      if (i < 2) vin = v3[i+1];
      else bus.start = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("t3_idle_busy", 32'(bus.busy), 0);

    // 4: start during CONV ignored
    v0 = vcnt;
    vin = 8'h33;
    exp_q.push_back(8'h33);
    pulse();
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #1 check("t4_one_valid", 32'(vcnt - v0), 1);
    check("t4_dout", 32'(bus.dout), 32'h33);
    check("t4_idle", 32'(bus.busy), 0);

    // 5: async reset after 4th decision
    v0 = vcnt;
    vin = 8'h77;
    pulse();
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("t5_sh", 32'(bus.sh_track), 0);
    check("t5_cen", 32'(bus.comp_en), 0);
    check("t5_dac", 32'(bus.dac_code), 0);
    check("t5_dout", 32'(bus.dout), 0);
    check("t5_valid", 32'(bus.valid), 0);
    check("t5_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("t5_no_valid", 32'(vcnt - v0), 0);
    vin = 8'h3C;
    exp_q.push_back(8'h3C);
    pulse();
    repeat (14) @(negedge clk);
    check("t5_dout_3c", 32'(bus.dout), 32'h3C);

    // 6: unknown comparator on the MSB trial
    vin = 8'hFF;
    pulse();
    repeat (2) @(negedge clk);
    mode = 3;
    #1;
    e6 = {(bus.comp === 1'b1), 7'h7F};
    exp_q.push_back(e6);
    @(negedge clk);
    mode = 0;
    repeat (12) @(negedge clk);
    check("t6_dout", 32'(bus.dout), 32'(e6));
    check("t6_idle", 32'(bus.busy), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
